// File: rtl/sb_rf_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Build option: SB_RF_BYPASS_EN forwards same-cycle writes to reads.
package sb_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 32;
  localparam int NRD_DEF    = 2;
  localparam int NWR_DEF    = 2;

  function automatic int aw_of(input int n);
    return $clog2(n);
  endfunction

  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/sb_rf_scoreboard.sv
// Busy-bit tracking: reservation grant, write clear, flush.
// Reservation set wins over a same-cycle write clear.
module sb_rf_scoreboard
  import sb_rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = NWR_DEF,
  localparam int AW   = aw_of(NREGS)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [NWR-1:0]   wen,
  input  logic [NWR*AW-1:0] wsel,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_sel,
  input  logic             flush,
  output logic             rsv_ok,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] clr;
  logic             sel_in;
  logic             sel_busy;
  logic [AW-1:0]    s;

  assign sel_in   = int'(rsv_sel) < NREGS;
  assign sel_busy = sel_in ? busy_q[rsv_sel] : 1'b0;
  assign rsv_ok   = rsv_en && sel_in && !flush &&
                    (rsv_sel == '0 || !sel_busy);

  always_comb begin
    clr = '0;
    s   = '0;
    for (int w = 0; w < NWR; w++) begin
      s = wsel[w*AW +: AW];
      if (wen[w] && s != '0 && int'(s) < NREGS)
        clr[s] = 1'b1;
    end
  end

  always_comb begin
    busy_d = busy_q & ~clr;
    if (rsv_ok && rsv_sel != '0)
      busy_d[rsv_sel] = 1'b1;
    if (flush)
      busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!n_rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/sb_register_file.sv
// Multi-port register file with busy scoreboard; r0 hardwired to 0.
// Build option: SB_RF_BYPASS_EN forwards same-cycle writes to reads.
module sb_register_file
  import sb_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF,
  localparam int AW    = aw_of(NREGS)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NRD*AW-1:0]     rsel,
  output logic [NRD*DATA_W-1:0] rdat,
  output logic [NRD-1:0]        rbusy,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*AW-1:0]     wsel,
  input  logic [NWR*DATA_W-1:0] wdat,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_sel,
  output logic                  rsv_ok,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec
);

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  busy;

  function automatic logic wr_hit(input logic [AW-1:0] s);
    return s != '0 && int'(s) < NREGS;
  endfunction

  sb_rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_sb (
    .clk      (clk),
    .n_rst    (n_rst),
    .wen      (wen),
    .wsel     (wsel),
    .rsv_en   (rsv_en),
    .rsv_sel  (rsv_sel),
    .flush    (flush),
    .rsv_ok   (rsv_ok),
    .busy_vec (busy)
  );

  assign busy_vec = busy;

  // Later ports overwrite earlier ones on a shared target.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++)
        if (wen[w] && wr_hit(wsel[w*AW +: AW]))
          mem[wsel[w*AW +: AW]] <= wdat[w*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    logic [AW-1:0] s;
    rdat  = '0;
    rbusy = '0;
    s     = '0;
    for (int p = 0; p < NRD; p++) begin
      s = rsel[p*AW +: AW];
      if (int'(s) < NREGS && s != '0) begin
        rdat[p*DATA_W +: DATA_W] = mem[s];
        rbusy[p] = busy[s];
      end
`ifdef SB_RF_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (wen[w] && wr_hit(s) && wsel[w*AW +: AW] == s) begin
          rdat[p*DATA_W +: DATA_W] = wdat[w*DATA_W +: DATA_W];
          rbusy[p] = rsv_ok && rsv_sel == s;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_sb_register_file.sv
// Self-checking bench for sb_register_file (NREGS=24 build).
// Expected read-backs are queued with each write and drained after the edge.
module tb_sb_register_file;

  localparam int DW = 32;
  localparam int NR = 24;
  localparam int A  = 5;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [2*A-1:0] rsel;
  logic [2*DW-1:0] rdat;
  logic [1:0]    rbusy;
  logic [1:0]    wen;
  logic [2*A-1:0] wsel;
  logic [2*DW-1:0] wdat;
  logic          rsv_en;
  logic [A-1:0]  rsv_sel;
  logic          rsv_ok;
  logic          flush;
  logic [NR-1:0] busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [A-1:0]  sel;
    logic [DW-1:0] val;
  } exp_t;

  exp_t exp_q[$];

  sb_register_file #(
    .DATA_W (DW),
    .NREGS  (NR),
    .NRD    (2),
    .NWR    (2)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .rsel     (rsel),
    .rdat     (rdat),
    .rbusy    (rbusy),
    .wen      (wen),
    .wsel     (wsel),
    .wdat     (wdat),
    .rsv_en   (rsv_en),
    .rsv_sel  (rsv_sel),
    .rsv_ok   (rsv_ok),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int port, input logic [A-1:0] sel,
                    input logic [DW-1:0] val);
    wen[port] = 1'b1;
    wsel[port*A +: A] = sel;
    wdat[port*DW +: DW] = val;
  endtask

  task automatic push(input logic [A-1:0] sel, input logic [DW-1:0] val);
    exp_t e;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wen = '0;
    rsv_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rsel = {e.sel, e.sel};
      #1;
      chk($sformatf("rd_r%0d_p0", e.sel), 64'(rdat[DW-1:0]), 64'(e.val));
      chk($sformatf("rd_r%0d_p1", e.sel), 64'(rdat[2*DW-1:DW]), 64'(e.val));
    end
  endtask

  initial begin
    n_rst = 1'b0;
    rsel = '0; wen = '0; wsel = '0; wdat = '0;
    rsv_en = 1'b0; rsv_sel = '0; flush = 1'b0;
    #2;
    // activity during reset must be ignored
    wr(0, 5'd5, 32'hFF);
    rsv_en = 1'b1;
    rsv_sel = 5'd3;
    tick();
    tick();
    n_rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy_vec), 64'h0);
    push(5'd5, 32'h0);
    drain();

    wr(0, 5'd5, 32'hDEADBEEF);
    wr(1, 5'd0, 32'h1234);
    push(5'd5, 32'hDEADBEEF);
    push(5'd0, 32'h0);
    tick();
    drain();

    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    push(5'd7, 32'h22);
    tick();
    drain();

    rsv_en = 1'b1;
    rsv_sel = 5'd3;
    #1;
    chk("rsv3_ok", 64'(rsv_ok), 64'h1);
    tick();
    chk("rsv3_busy", 64'(busy_vec), 64'h8);
    rsv_en = 1'b1;
    rsv_sel = 5'd3;
    rsel = {5'd3, 5'd3};
    #1;
    chk("rsv3_again", 64'(rsv_ok), 64'h0);
    chk("rbusy3", 64'(rbusy), 64'h3);
    rsv_en = 1'b0;
    wr(0, 5'd3, 32'h5);
    push(5'd3, 32'h5);
    tick();
    chk("wr3_clr", 64'(busy_vec), 64'h0);
    drain();

    rsv_en = 1'b1;
    rsv_sel = 5'd4;
    wr(1, 5'd4, 32'h9);
    push(5'd4, 32'h9);
    tick();
    chk("rsv_wr4_busy", 64'(busy_vec), 64'h10);
    drain();
    flush = 1'b1;
    rsv_en = 1'b1;
    rsv_sel = 5'd8;
    #1;
    chk("flush_rsv_ok", 64'(rsv_ok), 64'h0);
    tick();
    chk("flush_busy", 64'(busy_vec), 64'h0);
    push(5'd4, 32'h9);
    drain();

    wr(0, 5'd6, 32'h66);
    push(5'd6, 32'h66);
    tick();
    drain();
    wr(1, 5'd6, 32'hAB);
    rsel = {5'd0, 5'd6};
    #1;
`ifdef SB_RF_BYPASS_EN
    chk("bypass_r6", 64'(rdat[DW-1:0]), 64'hAB);
`else
    chk("bypass_r6", 64'(rdat[DW-1:0]), 64'h66);
`endif
    chk("bypass_rbusy", 64'(rbusy[0]), 64'h0);
    push(5'd6, 32'hAB);
    tick();
    drain();

    wr(0, 5'd30, 32'hCAFE);
    rsv_en = 1'b1;
    rsv_sel = 5'd30;
    #1;
    chk("r30_rsv_ok", 64'(rsv_ok), 64'h0);
    tick();
    chk("r30_busy", 64'(busy_vec), 64'h0);
    rsel = {5'd30, 5'd30};
    #1;
    chk("r30_rdat", 64'(rdat), 64'h0);
    chk("r30_rbusy", 64'(rbusy), 64'h0);
    push(5'd6, 32'hAB);
    drain();

    rsv_en = 1'b1;
    rsv_sel = 5'd0;
    #1;
    chk("r0_rsv_ok", 64'(rsv_ok), 64'h1);
    tick();
    chk("r0_busy", 64'(busy_vec), 64'h0);

    rsv_en = 1'b1;
    rsv_sel = 5'd9;
    tick();
    chk("rsv9_busy", 64'(busy_vec), 64'h200);
    n_rst = 1'b0;
    rsv_en = 1'b1;
    rsv_sel = 5'd10;
    tick();
    n_rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy_vec), 64'h0);
    push(5'd5, 32'h0);
    push(5'd6, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sb_register_file.md
SB_REGISTER_FILE -- requirements
Module: sb_register_file

Interface
REQ-001 Parameter DATA_W, default 32, width of each register in bits.
REQ-002 Parameter NREGS, default 32, register count (2..64, not necessarily a power of 2); AW = $clog2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 Ports, one per line:
  clk  in  1  sole clock, rising edge.
  n_rst  in  1  reset, synchronous, active-low.
  rsel  in  NRD x AW  read register select per port.
  rdat  out  NRD x DATA_W  read data per port.
  rbusy  out  NRD  busy flag of the register selected by that read port.
  wen  in  NWR  write enable per port.
  wsel  in  NWR x AW  write register select per port.
  wdat  in  NWR x DATA_W  write data per port.
  rsv_en  in  1  request to reserve (mark busy) rsv_sel.
  rsv_sel  in  AW  register to reserve.
  rsv_ok  out  1  reservation grant, combinational.
  flush  in  1  clear all busy bits.
  busy_vec  out  NREGS  current busy bit of every register.

Function
REQ-006 Reads are combinational: rdat[p] = reg[rsel[p]] and rbusy[p] = busy[rsel[p]]; if rsel[p] >= NREGS, then rdat[p] = 0 and rbusy[p] = 0.
REQ-007 Register 0 reads as 0 and is never busy; writes to it and reservations of it have no effect on state.
REQ-008 On a rising edge with wen[w] high and 0 < wsel[w] < NREGS, reg[wsel[w]] takes wdat[w] and its busy bit clears; select values >= NREGS are ignored.
REQ-009 If several write ports target the same register in one cycle, the highest-indexed port's data is stored.
REQ-010 rsv_ok = rsv_en and rsv_sel < NREGS and (rsv_sel == 0 or busy[rsv_sel] == 0) and flush == 0.
REQ-011 If rsv_ok is high and rsv_sel != 0, busy[rsv_sel] is set at the next edge.
REQ-012 If a granted reservation and a write target the same register in one cycle, the data is written and the busy bit ends set (set has priority over clear).
REQ-013 flush high clears every busy bit at the next edge and forces rsv_ok low; writes in the same cycle still update data.
REQ-014 Write latency is one cycle: the value is visible on rdat the cycle after the write edge (without bypass).
REQ-015 busy_vec is the registered busy state; bit 0 is always 0.

Reset
REQ-016 While n_rst is low at a rising edge, all registers clear to 0 and all busy bits clear to 0; writes, reservations and flush are ignored in that cycle.
REQ-017 Reset asserted mid-sequence discards all pending reservations; no state survives.

Configuration
REQ-018 Macro SB_RF_BYPASS_EN: when defined, a read port whose rsel matches a same-cycle active write (nonzero, in range) returns the highest-indexed matching wdat, and its rbusy is 0 unless the same cycle also reserves that register.
REQ-019 Without SB_RF_BYPASS_EN, reads return only the stored state; same-cycle writes are not visible.

Structure
REQ-020 Package sb_rf_pkg holds the default parameter constants, the AW derivation function and the word typedef (logic [DATA_W-1:0]).
REQ-021 Sub-module sb_rf_scoreboard holds the busy vector, reservation grant, set/clear priority and flush logic; data storage stays in the top module.

Verification
REQ-022 Reset, then write 0xDEADBEEF to r5 on port 0 -> the next cycle r5 reads 0xDEADBEEF on both read ports; r0 write of 0x1234 -> r0 reads 0.
REQ-023 Ports 0 and 1 both write r7 (0x11, 0x22) -> r7 = 0x22.
REQ-024 Reserve r3 -> busy_vec[3] = 1 and a second rsv_en on r3 gives rsv_ok = 0; write r3 = 0x5 -> busy clears and r3 = 0x5.
REQ-025 Reserve r4 and write r4 = 0x9 in the same cycle -> r4 = 0x9 and busy_vec[4] = 1; flush -> busy_vec = 0 and data unchanged.
REQ-026 With SB_RF_BYPASS_EN, write r6 = 0xAB while rsel[0] = 6 -> rdat[0] = 0xAB in the same cycle; without the macro -> old r6 value.
REQ-027 NREGS = 24: write r30 and reserve r30 -> no state change, rsv_ok = 0, and reading r30 returns 0; reset mid-reservation -> busy_vec = 0.
